machine_trap_ctrl: RTL and testbench

MACHINE_TRAP_CTRL -- requirements
Module: machine_trap_ctrl

---
 rtl/machine_trap_ctrl.sv | 144 ++++++++++++++
 tb/tb_machine_trap_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/machine_trap_ctrl.sv
// Machine-mode trap/return sequencer: arbitrates exceptions, interrupts, MRET.
// Optional vectored interrupt dispatch with TRAP_VECTORED_EN.
module machine_trap_ctrl (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        stall_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  input  logic        mstatus_mie_in,
  input  logic        meie_in,
  input  logic        msie_in,
  input  logic        mtie_in,
  input  logic        e_irq_in,
  input  logic        s_irq_in,
  input  logic        t_irq_in,
  input  logic        illegal_instr_in,
  input  logic        instr_misaligned_in,
  input  logic        ecall_in,
  input  logic        ld_misaligned_in,
  input  logic        st_misaligned_in,
  input  logic        mret_in,
  output logic        mie_clear_out,
  output logic        mie_set_out,
  output logic        set_cause_out,
  output logic        set_epc_out,
  output logic [31:0] cause_out,
  output logic [31:0] epc_out,
  output logic        redirect_out,
  output logic [31:0] redirect_pc_out,
  output logic        flush_out
);

  typedef enum logic [1:0] {
    IDLE,
    TRAP_ENTRY,
    TRAP_RETURN
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;

  logic        exc_hit, irq_hit;
  logic [3:0]  exc_code, irq_code;
  logic [31:0] base;
  logic [31:0] trap_pc;
  logic        unused_bits;

  always_comb begin
    exc_hit  = 1'b1;
    exc_code = 4'd0;
    if (instr_misaligned_in)   exc_code = 4'd0;
    else if (illegal_instr_in) exc_code = 4'd2;
    else if (ecall_in)         exc_code = 4'd11;
    else if (ld_misaligned_in) exc_code = 4'd4;
    else if (st_misaligned_in) exc_code = 4'd6;
    else                       exc_hit  = 1'b0;
  end

  always_comb begin
    irq_hit  = mstatus_mie_in;
    irq_code = 4'd0;
    if (meie_in && e_irq_in)      irq_code = 4'd11;
    else if (msie_in && s_irq_in) irq_code = 4'd3;
    else if (mtie_in && t_irq_in) irq_code = 4'd7;
    else                          irq_hit  = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    epc_d   = epc_q;
    if (state_q != IDLE) begin
      state_d = IDLE;
    end else if (!stall_in) begin
      if (exc_hit || irq_hit) begin
        state_d = TRAP_ENTRY;
        epc_d   = {pc_in[31:2], 2'b00};
        cause_d = exc_hit ? {1'b0, 27'b0, exc_code}
                          : {1'b1, 27'b0, irq_code};
      end else if (mret_in) begin
        state_d = TRAP_RETURN;
      end
    end
  end

  assign base = {mtvec_in[31:2], 2'b00};

`ifdef TRAP_VECTORED_EN
  always_comb begin
    trap_pc = base;
    if (mtvec_in[1:0] == 2'b01 && cause_q[31])
      trap_pc = base + {26'b0, cause_q[3:0], 2'b00};
  end
  assign unused_bits = ^pc_in[1:0];
`else
  assign trap_pc     = base;
  assign unused_bits = ^{pc_in[1:0], mtvec_in[1:0]};
`endif

  always_comb begin
    mie_clear_out   = 1'b0;
    mie_set_out     = 1'b0;
    set_cause_out   = 1'b0;
    set_epc_out     = 1'b0;
    redirect_out    = 1'b0;
    flush_out       = 1'b0;
    redirect_pc_out = 32'b0;
    case (state_q)
      TRAP_ENTRY: begin
        mie_clear_out   = 1'b1;
        set_cause_out   = 1'b1;
        set_epc_out     = 1'b1;
        redirect_out    = 1'b1;
        flush_out       = 1'b1;
        redirect_pc_out = trap_pc;
      end
      TRAP_RETURN: begin
        mie_set_out     = 1'b1;
        redirect_out    = 1'b1;
        flush_out       = 1'b1;
        redirect_pc_out = mepc_in;
      end
      default: ;
    endcase
  end

  assign cause_out = cause_q;
  assign epc_out   = epc_q;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      cause_q <= 32'b0;
      epc_q   <= 32'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      epc_q   <= epc_d;
    end
  end

endmodule

// File: tb/tb_machine_trap_ctrl.sv
// Scoreboard bench for machine_trap_ctrl: directed events, monitor pops
// expected responses whenever any strobe is seen.
module tb_machine_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic [31:0] pc, mtvec, mepc;
  logic        mie, meie, msie, mtie, eirq, sirq, tirq;
  logic        ill, imis, ecall, ldmis, stmis, mret;
  logic        mie_clr, mie_set, set_cause, set_epc, redir, flush;
  logic [31:0] cause, epc, rpc;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        ret;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] rpc;
  } exp_t;
  exp_t q[$];

  localparam int F_MIE = 0, F_MEIE = 1, F_MSIE = 2, F_MTIE = 3;
  localparam int F_EIRQ = 4, F_SIRQ = 5, F_TIRQ = 6, F_ILL = 7;
  localparam int F_IMIS = 8, F_ECALL = 9, F_LD = 10, F_ST = 11;
  localparam int F_MRET = 12, F_STALL = 13;

`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] R_MTI = 32'h21C;
  localparam logic [31:0] R_MEI = 32'h22C;
`else
  localparam logic [31:0] R_MTI = 32'h200;
  localparam logic [31:0] R_MEI = 32'h200;
`endif

  machine_trap_ctrl dut (
    .clk_in              (clk),
    .rst_n_in            (rst_n),
    .stall_in            (stall),
    .pc_in               (pc),
    .mtvec_in            (mtvec),
    .mepc_in             (mepc),
    .mstatus_mie_in      (mie),
    .meie_in             (meie),
    .msie_in             (msie),
    .mtie_in             (mtie),
    .e_irq_in            (eirq),
    .s_irq_in            (sirq),
    .t_irq_in            (tirq),
    .illegal_instr_in    (ill),
    .instr_misaligned_in (imis),
    .ecall_in            (ecall),
    .ld_misaligned_in    (ldmis),
    .st_misaligned_in    (stmis),
    .mret_in             (mret),
    .mie_clear_out       (mie_clr),
    .mie_set_out         (mie_set),
    .set_cause_out       (set_cause),
    .set_epc_out         (set_epc),
    .cause_out           (cause),
    .epc_out             (epc),
    .redirect_out        (redir),
    .redirect_pc_out     (rpc),
    .flush_out           (flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic r, input logic [31:0] c,
                      input logic [31:0] e, input logic [31:0] p);
    exp_t x;
    x.ret = r; x.cause = c; x.epc = e; x.rpc = p;
    q.push_back(x);
  endtask

  task automatic clear_in();
    {stall, mie, meie, msie, mtie, eirq, sirq, tirq} = '0;
    {ill, imis, ecall, ldmis, stmis, mret} = '0;
  endtask

  task automatic ev(input logic [31:0] p, input logic [31:0] tv,
                    input logic [31:0] ep, input logic [13:0] f);
    pc = p; mtvec = tv; mepc = ep;
    mie = f[F_MIE]; meie = f[F_MEIE]; msie = f[F_MSIE];
    mtie = f[F_MTIE]; eirq = f[F_EIRQ]; sirq = f[F_SIRQ];
    tirq = f[F_TIRQ]; ill = f[F_ILL]; imis = f[F_IMIS];
    ecall = f[F_ECALL]; ldmis = f[F_LD]; stmis = f[F_ST];
    mret = f[F_MRET]; stall = f[F_STALL];
    @(posedge clk); #1;
    clear_in();
    @(posedge clk); #1;
  endtask

  function automatic logic [13:0] fl(input int a, input int b = -1,
                                     input int c = -1, input int d = -1);
    logic [13:0] v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    if (d >= 0) v[d] = 1'b1;
    return v;
  endfunction

  // Monitor: any strobe in a cycle must match the oldest expectation.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (rst_n && (redir | flush | mie_clr | mie_set | set_cause | set_epc)) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: got redirect pc %h expected none", rpc);
        end else begin
          x = q.pop_front();
          chk("redirect", {31'b0, redir}, 32'd1);
          chk("flush", {31'b0, flush}, 32'd1);
          chk("redirect_pc", rpc, x.rpc);
          chk("mie_clear", {31'b0, mie_clr}, {31'b0, ~x.ret});
          chk("mie_set", {31'b0, mie_set}, {31'b0, x.ret});
          chk("set_cause", {31'b0, set_cause}, {31'b0, ~x.ret});
          chk("set_epc", {31'b0, set_epc}, {31'b0, ~x.ret});
          if (!x.ret) begin
            chk("cause", cause, x.cause);
            chk("epc", epc, x.epc);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; pc = '0; mtvec = '0; mepc = '0;
    clear_in();
    #3;
    chk("rst_strobes", {26'b0, redir, flush, mie_clr, mie_set, set_cause, set_epc}, 32'd0);
    chk("rst_cause", cause, 32'd0);
    chk("rst_epc", epc, 32'd0);
    chk("rst_rpc", rpc, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    push(0, 32'h2, 32'h100, 32'h200);
    ev(32'h100, 32'h200, 0, fl(F_ILL));
    push(0, 32'hB, 32'h104, 32'h200);
    ev(32'h104, 32'h200, 0, fl(F_MIE, F_MTIE, F_TIRQ, F_ECALL));
    push(0, 32'h8000000B, 32'h108, R_MEI);
    ev(32'h108, 32'h201, 0, fl(F_MIE, F_MEIE, F_MSIE, F_MTIE) | fl(F_EIRQ, F_SIRQ, F_TIRQ));
    ev(32'h10C, 32'h201, 0, fl(F_MEIE, F_MSIE, F_MTIE) | fl(F_EIRQ, F_SIRQ, F_TIRQ));
    push(1, 0, 0, 32'h400);
    ev(32'h110, 32'h200, 32'h400, fl(F_MRET));
    push(0, 32'h80000007, 32'h114, R_MTI);
    ev(32'h114, 32'h201, 0, fl(F_MIE, F_MTIE, F_TIRQ));
    ev(32'h118, 32'h200, 0, fl(F_STALL, F_ILL));
    push(0, 32'h0, 32'h11C, 32'h200);
    ev(32'h11C, 32'h201, 0, fl(F_IMIS, F_ILL, F_ECALL));
    push(0, 32'h4, 32'h120, 32'h300);
    ev(32'h123, 32'h300, 0, fl(F_LD, F_ST));
    push(0, 32'h6, 32'h124, 32'h300);
    ev(32'h124, 32'h300, 0, fl(F_ST));
    push(0, 32'h80000003, 32'h128, 32'h300);
    ev(32'h128, 32'h300, 0, fl(F_MIE, F_MSIE, F_SIRQ, F_MTIE) | fl(F_TIRQ));
    push(0, 32'h80000007, 32'h12C, 32'h300);
    ev(32'h12C, 32'h300, 32'h500, fl(F_MIE, F_MTIE, F_TIRQ, F_MRET));
    ev(32'h130, 32'h300, 0, fl(F_MIE, F_MTIE));

    // Reset asserted while TRAP_ENTRY is active
    pc = 32'h200; mtvec = 32'h600; ill = 1'b1;
    @(posedge clk); #1;
    clear_in();
    rst_n = 1'b0; #1;
    chk("midrst_strobes", {26'b0, redir, flush, mie_clr, mie_set, set_cause, set_epc}, 32'd0);
    chk("midrst_cause", cause, 32'd0);
    chk("midrst_epc", epc, 32'd0);
    chk("midrst_rpc", rpc, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    push(0, 32'h2, 32'h204, 32'h600);
    ev(32'h204, 32'h600, 0, fl(F_ILL));

    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
